input_buffer: RTL and testbench
===============================

# input_buffer

Per-virtual-channel input buffer of a router input port. Wraps one `circular_buffer` FIFO of flits and adds the wormhole packet state machine (IDLE → VA → SA). The state machine latches the route of each head flit, requests a downstream VC, then requests the switch until the tail flit leaves. Upstream it receives flits from the link. Downstream it feeds the VC allocator, the switch allocator and the crossbar.

## Interface
Parameters:
- `BUFFER_SIZE`, 8, flit capacity of the FIFO; power of two, ≥ 2.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_i` in `flit_novc_t`: incoming flit from the link.
- `write_i` in 1: push `data_i` this cycle.
- `read_i` in 1: switch grant; pop the front flit this cycle.
- `out_port_i` in `port_t`: route computed from the head on `data_i`; sampled only on a head write in IDLE.
- `vc_valid_i` in 1: VC allocator grant.
- `vc_new_i` in `VC_SIZE`: granted downstream VC id; sampled when `vc_valid_i` is high in VA.
- `data_o` out `flit_t`: front flit with `vc_id` = `downstream_vc_o`; don't-care when empty.
- `is_full_o`, `is_empty_o`, `on_off_o` out 1 each: FIFO status, passed through from `circular_buffer`.
- `out_port_o` out `port_t`: latched route of the current packet.
- `downstream_vc_o` out `VC_SIZE`: latched VC of the current packet.
- `vc_request_o` out 1: high in VA.
- `switch_request_o` out 1: high in SA while the FIFO is non-empty.
- `vc_allocatable_o` out 1: high in IDLE.
- `error_o` out 1: sticky protocol-violation flag.

## Operation
- States:
  - **IDLE**: `vc_allocatable_o`=1.
    - A write of HEAD or HEADTAIL pushes the flit, latches `out_port_i` and moves to VA.
    - A write of BODY or TAIL is dropped and sets `error_o`.
  - **VA**: `vc_request_o`=1. With `vc_valid_i`=1, latch `vc_new_i` and move to SA. Writes of BODY/TAIL are accepted.
  - **SA**: `switch_request_o` = `~is_empty_o`. A read whose front flit is TAIL or HEADTAIL moves to IDLE.
- `read_i` outside SA, or on an empty FIFO: ignored (not forwarded to the FIFO), sets `error_o`.
- Write of HEAD/HEADTAIL outside IDLE: dropped, sets `error_o`.
- Write while full with no effective read in the same cycle: dropped, sets `error_o`.
- Write while full together with an effective read: accepted, occupancy unchanged.
- Simultaneous write and read in SA: both take effect.
- HEADTAIL packets go IDLE → VA → SA → IDLE.
- `error_o` clears only on reset.

## Timing
- Reset values: state IDLE, FIFO empty.
  - `is_empty_o`=1, `is_full_o`=0, `on_off_o`=1.
  - `vc_request_o`=0, `switch_request_o`=0, `vc_allocatable_o`=1, `error_o`=0.
  - `out_port_o`=0, `downstream_vc_o`=0.
- Head written in cycle n: `vc_request_o`=1 from cycle n+1.
- `vc_valid_i` in cycle k (state VA): SA from k+1; `switch_request_o` goes high in k+1 if the FIFO is non-empty.
- `data_o` shows the front flit combinationally in the same cycle it is granted. The pop takes effect at the next edge.
- Tail popped in cycle m: IDLE and `vc_allocatable_o`=1 from m+1.
- Reset asserted mid-packet: at the next edge the FIFO is flushed and every output returns to its reset value. Flits in flight are discarded.

## Structure
- Package `noc_params` holds:
  - `flit_label_t` (HEAD, BODY, TAIL, HEADTAIL), `flit_novc_t`, `flit_t`, `port_t`;
  - `VC_SIZE`, `DEST_ADDR_SIZE_X/Y`, `HEAD_PAYLOAD_SIZE`;
  - the state enum `input_state_t` (IDLE, VA, SA).
- One sub-module: `circular_buffer` (data_i, read_i, write_i, rst, clk, data_o, is_full_o, is_empty_o, on_off_o), instantiated with the gated read/write strobes.
- This block contains only the FSM, the latches and the gating.

## Test plan
- Reset, then write HEAD(x=1,y=2) with `out_port_i`=EAST, then BODY, then TAIL. Give `vc_valid_i`=1 with `vc_new_i`=3 one cycle later, then grant `read_i` three times:
  - `vc_request_o` is high for exactly 1 cycle;
  - `data_o` returns HEAD/BODY/TAIL in order with `vc_id`=3;
  - state is IDLE with `vc_allocatable_o`=1 the cycle after the TAIL read.
- HEADTAIL write, VA grant, one read → IDLE two cycles after the grant; `is_empty_o`=1; `error_o`=0.
- BODY written in IDLE → FIFO stays empty (`is_empty_o`=1); `error_o`=1 and stays 1 until `rst`.
- Fill `BUFFER_SIZE`=8 flits (HEAD + 7 BODY) in SA:
  - `is_full_o`=1;
  - a 9th write alone is dropped and sets `error_o`;
  - a write with a simultaneous read keeps the count at 8 and preserves order.
- `rst`=1 in SA with 4 flits buffered → next cycle `is_empty_o`=1, `switch_request_o`=0, `downstream_vc_o`=0, state IDLE.
- `read_i` in VA → ignored: the FIFO count is unchanged and `error_o`=1.

Source files
------------

// File: rtl/input_buffer_pkg.sv
// rtl/input_buffer_pkg.sv - shared NoC flit, port and input-state types
package noc_params;

  localparam int VC_SIZE           = 2;
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int HEAD_PAYLOAD_SIZE = 8;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  // Head flits carry the destination in the upper data bits
  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_novc_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, VA, SA} input_state_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/input_buffer_buffer.sv
// rtl/input_buffer_buffer.sv - circular FIFO of flits with full/empty/on-off status
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  flit_novc_t data_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       rst,
  input  logic       clk,
  output flit_novc_t data_o,
  output logic       is_full_o,
  output logic       is_empty_o,
  output logic       on_off_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  flit_novc_t       mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             rd_en;
  logic             wr_en;

  // Never pop empty; a push into a full FIFO only lands when a pop frees the slot
  always_comb begin
    rd_en = read_i & ~is_empty_o;
    wr_en = write_i & (~is_full_o | rd_en);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flit storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end

  assign data_o     = mem[rd_ptr];
  assign is_full_o  = (count == (PTR_W+1)'(BUFFER_SIZE));
  assign is_empty_o = (count == '0);
  // On/off credit: upstream may keep sending while at least two slots are free
  assign on_off_o   = (count < (PTR_W+1)'(BUFFER_SIZE - 1));

endmodule

// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - per-VC input buffer with wormhole IDLE/VA/SA state machine
module input_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_novc_t         data_i,
  input  logic               write_i,
  input  logic               read_i,
  input  port_t              out_port_i,
  input  logic               vc_valid_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  output flit_t              data_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               on_off_o,
  output port_t              out_port_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output logic               vc_request_o,
  output logic               switch_request_o,
  output logic               vc_allocatable_o,
  output logic               error_o
);

  input_state_t state_q;
  flit_novc_t   front;
  logic         rd_eff;
  logic         label_ok;
  logic         wr_eff;
  logic         err_now;

  circular_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_buffer (
    .data_i     (data_i),
    .read_i     (rd_eff),
    .write_i    (wr_eff),
    .rst        (rst),
    .clk        (clk),
    .data_o     (front),
    .is_full_o  (is_full_o),
    .is_empty_o (is_empty_o),
    .on_off_o   (on_off_o)
  );

  // Gate the strobes: heads only open a packet in IDLE, bodies/tails only continue one
  always_comb begin
    rd_eff   = read_i & (state_q == SA) & ~is_empty_o;
    label_ok = (state_q == IDLE) ? is_head(data_i.flit_label) : ~is_head(data_i.flit_label);
    wr_eff   = write_i & label_ok & (~is_full_o | rd_eff);
    err_now  = (read_i & ~rd_eff) | (write_i & ~wr_eff);
  end

  // Wormhole packet FSM with registered request flags, route/VC latches and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      out_port_o       <= LOCAL;
      downstream_vc_o  <= '0;
      vc_request_o     <= 1'b0;
      vc_allocatable_o <= 1'b1;
      error_o          <= 1'b0;
    end else begin
      error_o <= error_o | err_now;
      case (state_q)
        IDLE: begin
          if (wr_eff) begin
            out_port_o       <= out_port_i;
            state_q          <= VA;
            vc_request_o     <= 1'b1;
            vc_allocatable_o <= 1'b0;
          end
        end
        VA: begin
          if (vc_valid_i) begin
            downstream_vc_o <= vc_new_i;
            state_q         <= SA;
            vc_request_o    <= 1'b0;
          end
        end
        SA: begin
          if (rd_eff && is_tail(front.flit_label)) begin
            state_q          <= IDLE;
            vc_allocatable_o <= 1'b1;
          end
        end
        default: begin
          state_q          <= IDLE;
          vc_request_o     <= 1'b0;
          vc_allocatable_o <= 1'b1;
        end
      endcase
    end
  end

  // Front flit re-tagged with the downstream VC of the current packet
  always_comb begin
    data_o            = '0;
    data_o.flit_label = front.flit_label;
    data_o.vc_id      = downstream_vc_o;
    data_o.data       = front.data;
  end

  assign switch_request_o = (state_q == SA) & ~is_empty_o;

endmodule

// File: tb/tb_input_buffer.sv
// tb/tb_input_buffer.sv - self-checking bench for input_buffer
module tb_input_buffer;
  import noc_params::*;

  localparam int BUFFER_SIZE = 8;
  localparam int M_IDLE = 0;
  localparam int M_VA   = 1;
  localparam int M_SA   = 2;

  logic               clk;
  logic               rst;
  flit_novc_t         data_i;
  logic               write_i;
  logic               read_i;
  port_t              out_port_i;
  logic               vc_valid_i;
  logic [VC_SIZE-1:0] vc_new_i;
  flit_t              data_o;
  logic               is_full_o;
  logic               is_empty_o;
  logic               on_off_o;
  port_t              out_port_o;
  logic [VC_SIZE-1:0] downstream_vc_o;
  logic               vc_request_o;
  logic               switch_request_o;
  logic               vc_allocatable_o;
  logic               error_o;

  input_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .write_i          (write_i),
    .read_i           (read_i),
    .out_port_i       (out_port_i),
    .vc_valid_i       (vc_valid_i),
    .vc_new_i         (vc_new_i),
    .data_o           (data_o),
    .is_full_o        (is_full_o),
    .is_empty_o       (is_empty_o),
    .on_off_o         (on_off_o),
    .out_port_o       (out_port_o),
    .downstream_vc_o  (downstream_vc_o),
    .vc_request_o     (vc_request_o),
    .switch_request_o (switch_request_o),
    .vc_allocatable_o (vc_allocatable_o),
    .error_o          (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: packet phase, FIFO contents, latched route/VC, sticky error
  int               m_st;
  flit_novc_t       m_q[$];
  port_t            m_port;
  logic [1:0]       m_vc;
  logic             m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r_rst, input logic w, input flit_novc_t d,
                            input logic r, input port_t p, input logic vv, input logic [1:0] vc);
    bit rd_ok, wr_ok, head, legal;
    if (r_rst) begin
      m_st = M_IDLE; m_q.delete(); m_port = LOCAL; m_vc = 0; m_err = 0;
      return;
    end
    rd_ok = r && (m_st == M_SA) && (m_q.size() > 0);
    head  = (d.flit_label == HEAD) || (d.flit_label == HEADTAIL);
    legal = (m_st == M_IDLE) ? head : !head;
    wr_ok = w && legal && ((m_q.size() < BUFFER_SIZE) || rd_ok);
    if ((r && !rd_ok) || (w && !wr_ok)) m_err = 1;
    if (m_st == M_IDLE && wr_ok) begin
      m_port = p; m_st = M_VA;
    end else if (m_st == M_VA && vv) begin
      m_vc = vc; m_st = M_SA;
    end else if (m_st == M_SA && rd_ok &&
                 (m_q[0].flit_label == TAIL || m_q[0].flit_label == HEADTAIL)) begin
      m_st = M_IDLE;
    end
    if (rd_ok) void'(m_q.pop_front());
    if (wr_ok) m_q.push_back(d);
  endtask

  task automatic compare_model();
    chk("m_empty", 32'(is_empty_o), 32'(m_q.size() == 0));
    chk("m_full", 32'(is_full_o), 32'(m_q.size() == BUFFER_SIZE));
    chk("m_on_off", 32'(on_off_o), 32'(m_q.size() <= BUFFER_SIZE - 2));
    chk("m_vc_req", 32'(vc_request_o), 32'(m_st == M_VA));
    chk("m_sw_req", 32'(switch_request_o), 32'((m_st == M_SA) && (m_q.size() > 0)));
    chk("m_alloc", 32'(vc_allocatable_o), 32'(m_st == M_IDLE));
    chk("m_error", 32'(error_o), 32'(m_err));
    chk("m_out_port", 32'(out_port_o), 32'(m_port));
    chk("m_dvc", 32'(downstream_vc_o), 32'(m_vc));
    if (m_q.size() > 0) begin
      chk("m_front_label", 32'(data_o.flit_label), 32'(m_q[0].flit_label));
      chk("m_front_vc", 32'(data_o.vc_id), 32'(m_vc));
      chk("m_front_data", 32'(data_o.data), 32'(m_q[0].data));
    end
  endtask

  task automatic step(input logic r_rst, input logic w, input flit_label_t lbl,
                      input logic [15:0] dat, input logic r, input port_t p,
                      input logic vv, input logic [1:0] vc);
    flit_novc_t d;
    d.flit_label = lbl;
    d.data       = dat;
    rst = r_rst; write_i = w; data_i = d; read_i = r;
    out_port_i = p; vc_valid_i = vv; vc_new_i = vc;
    model_edge(r_rst, w, d, r, p, vv, vc);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        rst, wr;
    flit_label_t lbl;
    logic [15:0] dat;
    logic        rd;
    port_t       port;
    logic        vv;
    logic [1:0]  vcn;
    logic        e_empty, e_vcreq, e_swreq, e_alloc, e_err;
    flit_label_t e_lbl;
    logic [1:0]  e_vcid;
    port_t       e_port;
  } vec_t;

  function automatic vec_t mkv(logic r_rst, logic wr, flit_label_t lbl, logic [15:0] dat,
                               logic rd, port_t port, logic vv, logic [1:0] vcn,
                               logic e_empty, logic e_vcreq, logic e_swreq, logic e_alloc,
                               logic e_err, flit_label_t e_lbl, logic [1:0] e_vcid, port_t e_port);
    vec_t v;
    v.rst = r_rst; v.wr = wr; v.lbl = lbl; v.dat = dat; v.rd = rd; v.port = port;
    v.vv = vv; v.vcn = vcn; v.e_empty = e_empty; v.e_vcreq = e_vcreq; v.e_swreq = e_swreq;
    v.e_alloc = e_alloc; v.e_err = e_err; v.e_lbl = e_lbl; v.e_vcid = e_vcid; v.e_port = e_port;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst = 1'b1; write_i = 1'b0; read_i = 1'b0; data_i = '0;
    out_port_i = LOCAL; vc_valid_i = 1'b0; vc_new_i = '0;
    m_st = M_IDLE; m_port = LOCAL; m_vc = 0; m_err = 0;

    //                rst wr lbl       dat      rd port   vv vcn  emp vrq srq alc err e_lbl     vc e_port
    tbl.push_back(mkv(1, 0, BODY,     16'h0000, 0, LOCAL, 0, 0,   1,  0,  0,  1,  0,  HEAD,     0, LOCAL));
    tbl.push_back(mkv(0, 1, HEAD,     16'h1200, 0, EAST,  0, 0,   0,  1,  0,  0,  0,  HEAD,     0, EAST));
    tbl.push_back(mkv(0, 1, BODY,     16'h0001, 0, LOCAL, 1, 3,   0,  0,  1,  0,  0,  HEAD,     3, EAST));
    tbl.push_back(mkv(0, 1, TAIL,     16'h0002, 0, LOCAL, 0, 0,   0,  0,  1,  0,  0,  HEAD,     3, EAST));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 1, LOCAL, 0, 0,   0,  0,  1,  0,  0,  BODY,     3, EAST));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 1, LOCAL, 0, 0,   0,  0,  1,  0,  0,  TAIL,     3, EAST));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 1, LOCAL, 0, 0,   1,  0,  0,  1,  0,  HEAD,     0, EAST));
    tbl.push_back(mkv(0, 1, HEADTAIL, 16'h0203, 0, NORTH, 0, 0,   0,  1,  0,  0,  0,  HEADTAIL, 3, NORTH));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 0, LOCAL, 1, 1,   0,  0,  1,  0,  0,  HEADTAIL, 1, NORTH));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 1, LOCAL, 0, 0,   1,  0,  0,  1,  0,  HEAD,     0, NORTH));
    tbl.push_back(mkv(0, 1, BODY,     16'h0005, 0, LOCAL, 0, 0,   1,  0,  0,  1,  1,  HEAD,     0, NORTH));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 0, LOCAL, 0, 0,   1,  0,  0,  1,  1,  HEAD,     0, NORTH));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 0, LOCAL, 0, 0,   1,  0,  0,  1,  1,  HEAD,     0, NORTH));
    tbl.push_back(mkv(1, 0, BODY,     16'h0000, 0, LOCAL, 0, 0,   1,  0,  0,  1,  0,  HEAD,     0, LOCAL));
    tbl.push_back(mkv(0, 1, HEAD,     16'h0100, 0, WEST,  0, 0,   0,  1,  0,  0,  0,  HEAD,     0, WEST));
    tbl.push_back(mkv(0, 0, BODY,     16'h0000, 1, LOCAL, 0, 0,   0,  1,  0,  0,  1,  HEAD,     0, WEST));
    tbl.push_back(mkv(1, 0, BODY,     16'h0000, 0, LOCAL, 0, 0,   1,  0,  0,  1,  0,  HEAD,     0, LOCAL));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].lbl, tbl[i].dat, tbl[i].rd, tbl[i].port, tbl[i].vv, tbl[i].vcn);
      chk($sformatf("t%0d_empty", i), 32'(is_empty_o), 32'(tbl[i].e_empty));
      chk($sformatf("t%0d_vc_req", i), 32'(vc_request_o), 32'(tbl[i].e_vcreq));
      chk($sformatf("t%0d_sw_req", i), 32'(switch_request_o), 32'(tbl[i].e_swreq));
      chk($sformatf("t%0d_alloc", i), 32'(vc_allocatable_o), 32'(tbl[i].e_alloc));
      chk($sformatf("t%0d_error", i), 32'(error_o), 32'(tbl[i].e_err));
      chk($sformatf("t%0d_port", i), 32'(out_port_o), 32'(tbl[i].e_port));
      if (!tbl[i].e_empty) begin
        chk($sformatf("t%0d_label", i), 32'(data_o.flit_label), 32'(tbl[i].e_lbl));
        chk($sformatf("t%0d_vcid", i), 32'(data_o.vc_id), 32'(tbl[i].e_vcid));
      end
    end

    // Fill to capacity in SA, overflow alone, then overflow with a concurrent read
    step(0, 1, HEAD, 16'h0000, 0, SOUTH, 0, 0);
    step(0, 0, BODY, 16'h0000, 0, LOCAL, 1, 2);
    for (int i = 1; i <= 7; i++) step(0, 1, BODY, 16'(i), 0, LOCAL, 0, 0);
    chk("fill_full", 32'(is_full_o), 32'd1);
    chk("fill_on_off", 32'(on_off_o), 32'd0);
    chk("fill_err_clean", 32'(error_o), 32'd0);
    step(0, 1, BODY, 16'h0063, 0, LOCAL, 0, 0);
    chk("ovf_full", 32'(is_full_o), 32'd1);
    chk("ovf_error", 32'(error_o), 32'd1);
    chk("ovf_front", 32'(data_o.data), 32'd0);
    step(0, 1, BODY, 16'h0008, 1, LOCAL, 0, 0);
    chk("wr_rd_full", 32'(is_full_o), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("order_%0d", i), 32'(data_o.data), 32'(i));
      chk($sformatf("order_vc_%0d", i), 32'(data_o.vc_id), 32'd2);
      step(0, 0, BODY, 16'h0000, 1, LOCAL, 0, 0);
    end
    chk("drain_empty", 32'(is_empty_o), 32'd1);
    chk("drain_sw_req", 32'(switch_request_o), 32'd0);

    // Reset mid-packet with four flits buffered
    step(1, 0, BODY, 16'h0000, 0, LOCAL, 0, 0);
    step(0, 1, HEAD, 16'h0300, 0, EAST, 0, 0);
    step(0, 0, BODY, 16'h0000, 0, LOCAL, 1, 3);
    for (int i = 0; i < 3; i++) step(0, 1, BODY, 16'(i), 0, LOCAL, 0, 0);
    chk("pre_rst_sw_req", 32'(switch_request_o), 32'd1);
    step(1, 0, BODY, 16'h0000, 0, LOCAL, 0, 0);
    chk("rst_empty", 32'(is_empty_o), 32'd1);
    chk("rst_sw_req", 32'(switch_request_o), 32'd0);
    chk("rst_dvc", 32'(downstream_vc_o), 32'd0);
    chk("rst_alloc", 32'(vc_allocatable_o), 32'd1);
    chk("rst_port", 32'(out_port_o), 32'(LOCAL));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, w, r, vv;
      flit_label_t lbl;
      r_rst = ($urandom_range(0, 63) == 0);
      w     = ($urandom_range(0, 1) == 1);
      r     = ($urandom_range(0, 1) == 1);
      vv    = ($urandom_range(0, 2) == 0);
      lbl   = flit_label_t'($urandom_range(0, 3));
      step(r_rst, w, lbl, 16'($urandom), r, port_t'($urandom_range(0, 4)), vv, 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
